// File: rtl/spu_perm_pkg.sv
// Shared definitions for the SPU permute (odd) pipe.
//   QW_W          : quadword width
//   TAG_W_DEF     : default target-register tag width (128-entry register file)
//   TAG_W_MAX     : widest tag a stage record can carry
//   OP_*          : rotate-and-mask opcode encodings (5..7 reserved)
//   stage_t       : per-stage pipeline record {valid, rt, data, bytes, bits}
//   op_is_legal() : true for the five implemented opcodes
package spu_perm_pkg;

    localparam int QW_W      = 128;
    localparam int TAG_W_DEF = 7;
    localparam int TAG_W_MAX = 16;

    localparam logic [2:0] OP_ROTQMBI   = 3'd0;
    localparam logic [2:0] OP_ROTQMBII  = 3'd1;
    localparam logic [2:0] OP_ROTQMBY   = 3'd2;
    localparam logic [2:0] OP_ROTQMBYI  = 3'd3;
    localparam logic [2:0] OP_ROTQMBYBI = 3'd4;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_MAX-1:0] rt;
        logic [QW_W-1:0]      data;
        logic [4:0]           bytes;
        logic [2:0]           bits;
    } stage_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_ROTQMBYBI;
    endfunction

endpackage

// File: rtl/qw_shr.sv
// Combinational 128-bit zero-fill right shift, split into two independent
// halves so the caller can place a register between them.
//   byte_in/bytes/byte_out : shift right by bytes*8 (bytes >= 16 yields zero)
//   bit_in/bits/bit_out    : shift right by bits (0..7)
// Bit numbering is big-endian at the architectural level (bit 0 = MSB), so a
// move toward higher architectural bit numbers is a plain >> on [127:0].
module qw_shr
    import spu_perm_pkg::*;
(
    input  logic [QW_W-1:0] byte_in,
    input  logic [4:0]      bytes,
    output logic [QW_W-1:0] byte_out,
    input  logic [QW_W-1:0] bit_in,
    input  logic [2:0]      bits,
    output logic [QW_W-1:0] bit_out
);

    assign byte_out = byte_in >> {bytes, 3'b000};
    assign bit_out  = bit_in >> bits;

endmodule

// File: rtl/perm_rotqm_pipe.sv
// Pipelined rotate-and-mask unit (rotqmbi, rotqmbii, rotqmby, rotqmbyi,
// rotqmbybi): zero-filling right shift of a quadword, fixed LATENCY.
//   clk, rst_n          : clock, asynchronous active-low reset
//   valid_in, op        : issue strobe and opcode (5..7 reserved, dropped)
//   ra, rb, imm7        : source quadword, count register, I7 immediate
//   rt_in               : target tag travelling with the op
//   flush               : kill every in-flight op, including one issued now
//   valid_out           : one-cycle pulse per completed op
//   result, rt_out      : shifted quadword and its tag; hold when idle
// Stage 1 decodes the count, stage 2 byte-shifts, stage 3 bit-shifts,
// stages 4..LATENCY are pure delay. TAG_W must not exceed TAG_W_MAX.
module perm_rotqm_pipe
    import spu_perm_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int TAG_W   = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [2:0]       op,
    input  logic [QW_W-1:0]  ra,
    input  logic [QW_W-1:0]  rb,
    input  logic [6:0]       imm7,
    input  logic [TAG_W-1:0] rt_in,
    input  logic             flush,
    output logic             valid_out,
    output logic [QW_W-1:0]  result,
    output logic [TAG_W-1:0] rt_out
);

    stage_t          st_d [1:LATENCY];
    stage_t          st_q [1:LATENCY];
    logic [QW_W-1:0] byte_shr;
    logic [QW_W-1:0] bit_shr;
    logic            unused_ok;

    qw_shr u_shr (
        .byte_in  (st_q[1].data),
        .bytes    (st_q[1].bytes),
        .byte_out (byte_shr),
        .bit_in   (st_q[2].data),
        .bits     (st_q[2].bits),
        .bit_out  (bit_shr)
    );

    // Architectural bit k of rb is [127-k]; of imm7 is [6-k]. The count is the
    // two's-complement negation of the field, wrapped to the field width.
    always_comb begin
        for (int k = 1; k <= LATENCY; k++) begin
            st_d[k] = '0;
        end

        // ---- stage 1: count decode ----
        st_d[1].valid = valid_in && op_is_legal(op) && !flush;
        st_d[1].rt    = TAG_W_MAX'(rt_in);
        st_d[1].data  = ra;
        case (op)
            OP_ROTQMBI:   st_d[1].bits  = 3'd0 - rb[98:96];   // rb[29:31]
            OP_ROTQMBII:  st_d[1].bits  = 3'd0 - imm7[2:0];   // imm7[4:6]
            OP_ROTQMBY:   st_d[1].bytes = 5'd0 - rb[100:96];  // rb[27:31]
            OP_ROTQMBYI:  st_d[1].bytes = 5'd0 - imm7[4:0];   // imm7[2:6]
            OP_ROTQMBYBI: st_d[1].bytes = 5'd0 - rb[103:99];  // rb[24:28]
            default: ;
        endcase

        // ---- stage 2: byte shift ----
        st_d[2].valid = st_q[1].valid && !flush;
        st_d[2].rt    = st_q[1].rt;
        st_d[2].data  = byte_shr;
        st_d[2].bits  = st_q[1].bits;

        // ---- stage 3: bit shift ----
        st_d[3].valid = st_q[2].valid && !flush;
        st_d[3].rt    = st_q[2].rt;
        st_d[3].data  = bit_shr;

        // ---- stages 4..LATENCY: delay tail ----
        for (int k = 4; k <= LATENCY; k++) begin
            st_d[k]       = st_q[k-1];
            st_d[k].valid = st_q[k-1].valid && !flush;
        end
    end

    // The last stage only captures a valid op so result/rt_out hold between
    // pulses; earlier stages may carry stale payload behind a cleared valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= LATENCY; k++) begin
                st_q[k] <= '0;
            end
        end else begin
            for (int k = 1; k <= LATENCY; k++) begin
                if (k < LATENCY || st_d[k].valid) begin
                    st_q[k] <= st_d[k];
                end else begin
                    st_q[k].valid <= 1'b0;
                end
            end
        end
    end

    assign valid_out = st_q[LATENCY].valid;
    assign result    = st_q[LATENCY].data;
    assign rt_out    = TAG_W'(st_q[LATENCY].rt);

    // Count fields past their stage are constant zero; fold them away here.
    always_comb begin
        unused_ok = ^{rb[127:104], rb[95:0], imm7[6:5]};
        for (int k = 2; k <= LATENCY; k++) begin
            unused_ok = unused_ok ^ (^st_q[k].bytes);
        end
        for (int k = 3; k <= LATENCY; k++) begin
            unused_ok = unused_ok ^ (^st_q[k].bits);
        end
    end

endmodule

// File: tb/tb_perm_rotqm_pipe.sv
module tb_perm_rotqm_pipe;
    import spu_perm_pkg::*;

    localparam int LAT = 4;
    localparam int TW  = 7;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            valid_in = 1'b0;
    logic [2:0]      op = '0;
    logic [127:0]    ra = '0;
    logic [127:0]    rb = '0;
    logic [6:0]      imm7 = '0;
    logic [TW-1:0]   rt_in = '0;
    logic            flush = 1'b0;
    logic            valid_out;
    logic [127:0]    result;
    logic [TW-1:0]   rt_out;

    always #5 clk = ~clk;

    perm_rotqm_pipe #(.LATENCY(LAT), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .op(op), .ra(ra), .rb(rb),
        .imm7(imm7), .rt_in(rt_in), .flush(flush), .valid_out(valid_out),
        .result(result), .rt_out(rt_out)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_w(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", name, act, req);
        end
    endtask

    // ---------------- reference model (architectural bit numbering) ----------------
    function automatic int fld(input logic [127:0] v, input int lo, input int hi);
        int r;
        r = 0;
        for (int k = lo; k <= hi; k++) r = r * 2 + int'(v[127-k]);
        return r;
    endfunction

    function automatic int ifld(input logic [6:0] v, input int lo, input int hi);
        int r;
        r = 0;
        for (int k = lo; k <= hi; k++) r = r * 2 + int'(v[6-k]);
        return r;
    endfunction

    function automatic logic [127:0] ref_shift(input logic [2:0] o, input logic [127:0] a,
                                               input logic [127:0] b, input logic [6:0] i);
        int nbytes, nbits;
        logic [127:0] x, y;
        nbytes = 0;
        nbits  = 0;
        case (o)
            3'd0: nbits  = (8 - fld(b, 29, 31)) % 8;
            3'd1: nbits  = (8 - ifld(i, 4, 6)) % 8;
            3'd2: nbytes = (32 - fld(b, 27, 31)) % 32;
            3'd3: nbytes = (32 - ifld(i, 2, 6)) % 32;
            3'd4: nbytes = (32 - fld(b, 24, 28)) % 32;
            default: ;
        endcase
        x = '0;
        for (int bb = 0; bb < 16; bb++)
            for (int k = 0; k < 8; k++)
                if (bb >= nbytes) x[127-(8*bb+k)] = a[127-(8*(bb-nbytes)+k)];
        y = '0;
        for (int bt = 0; bt < 128; bt++)
            if (bt >= nbits) y[127-bt] = x[127-(bt-nbits)];
        return y;
    endfunction

    typedef struct {
        int            due;
        logic [TW-1:0] rt;
        logic [127:0]  res;
    } exp_t;

    exp_t          exp_q[$];
    int            cyc = 0;
    logic [127:0]  last_res = '0;
    logic [TW-1:0] last_rt = '0;
    int            pulses = 0;
    int            run = 0;
    int            max_run = 0;
    logic [TW-1:0] seen_rt = '0;
    logic [127:0]  seen_res = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            last_res = '0;
            last_rt  = '0;
        end else begin
            cyc++;
            if (flush) exp_q.delete();
            else if (valid_in && op <= 3'd4)
                exp_q.push_back('{due: cyc + LAT - 1, rt: rt_in, res: ref_shift(op, ra, rb, imm7)});
        end
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            check_b("sb_valid", valid_out, 1'b1);
            check_w("sb_result", result, exp_q[0].res);
            check_w("sb_rt", 128'(rt_out), 128'(exp_q[0].rt));
            last_res = exp_q[0].res;
            last_rt  = exp_q[0].rt;
            void'(exp_q.pop_front());
        end else begin
            check_b("sb_idle_valid", valid_out, 1'b0);
            check_w("sb_hold_result", result, last_res);
            check_w("sb_hold_rt", 128'(rt_out), 128'(last_rt));
        end
        if (valid_out) begin
            pulses++;
            run++;
            if (run > max_run) max_run = run;
            seen_rt  = rt_out;
            seen_res = result;
        end else begin
            run = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [2:0] o, input logic [127:0] a,
                         input logic [127:0] b, input logic [6:0] i, input logic [TW-1:0] t,
                         input logic f);
        @(posedge clk);
        #1;
        valid_in = v; op = o; ra = a; rb = b; imm7 = i; rt_in = t; flush = f;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 3'd0, '0, '0, '0, '0, 1'b0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    typedef struct {
        logic [2:0]    op;
        logic [127:0]  ra;
        logic [127:0]  rb;
        logic [6:0]    imm7;
        logic [TW-1:0] rt;
        logic [127:0]  exp;
    } tvec_t;

    tvec_t tv [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] ea, eb;
        logic [6:0]   ei;
        logic [2:0]   eo;
        int           lat;

        tv[0] = '{3'd0, 128'h8000_0000_0000_0000_0000_0000_0000_0001, {32'h7, 96'h0}, 7'h00, 7'h11,
                  128'h4000_0000_0000_0000_0000_0000_0000_0000};
        tv[1] = '{3'd3, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, '0, 7'h7D, 7'h12,
                  128'h0000_0000_1122_3344_5566_7788_99AA_BBCC};
        tv[2] = '{3'd3, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, '0, 7'h70, 7'h13, '0};
        tv[3] = '{3'd4, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98, '0, 7'h7F, 7'h14,
                  128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98};
        tv[4] = '{3'd1, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98, '1, 7'h00, 7'h15,
                  128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98};
        tv[5] = '{3'd0, 128'h8000_0000_0000_0000_0000_0000_0000_0000, {32'hFFFF_FFFD, 96'h0}, 7'h00, 7'h16,
                  128'h1000_0000_0000_0000_0000_0000_0000_0000};
        tv[6] = '{3'd2, 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10, {32'h1F, 96'h0}, 7'h00, 7'h17,
                  128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F};
        tv[7] = '{3'd4, 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10, {32'hF8, 96'h0}, 7'h00, 7'h18,
                  128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F};
        tv[8] = '{3'd1, 128'hF000_0000_0000_0000_0000_0000_0000_0000, '0, 7'h05, 7'h19,
                  128'h1E00_0000_0000_0000_0000_0000_0000_0000};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_b("reset_valid", valid_out, 1'b0);
        check_w("reset_result", result, '0);
        check_w("reset_rt", 128'(rt_out), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // directed vectors: value and latency
        for (int v = 0; v < 9; v++) begin
            drive(1'b1, tv[v].op, tv[v].ra, tv[v].rb, tv[v].imm7, tv[v].rt, 1'b0);
            idle(1);
            lat = 0;
            for (int w = 1; w <= 10; w++) begin
                @(negedge clk);
                if (valid_out) begin
                    lat = w;
                    break;
                end
            end
            check_w("tv_latency", 128'(lat), 128'(LAT));
            check_w("tv_result", result, tv[v].exp);
            check_w("tv_rt", 128'(rt_out), 128'(tv[v].rt));
        end
        idle(3);

        // eight back-to-back ops
        pulses = 0;
        max_run = 0;
        for (int k = 0; k < 8; k++)
            drive(1'b1, 3'($urandom_range(0, 4)), rnd128(), rnd128(), 7'($urandom()), 7'(40 + k), 1'b0);
        idle(12);
        check_w("b2b_pulses", 128'(pulses), 128'(8));
        check_w("b2b_run", 128'(max_run), 128'(8));

        // flush kills three in flight plus one issued the same cycle
        pulses = 0;
        for (int k = 0; k < 3; k++)
            drive(1'b1, 3'($urandom_range(0, 4)), rnd128(), rnd128(), 7'($urandom()), 7'(60 + k), 1'b0);
        drive(1'b1, 3'd2, rnd128(), rnd128(), 7'h00, 7'h3F, 1'b1);
        ea = rnd128(); eb = rnd128(); ei = 7'($urandom()); eo = 3'd0;
        drive(1'b1, eo, ea, eb, ei, 7'h55, 1'b0);
        idle(12);
        check_w("flush_pulses", 128'(pulses), 128'(1));
        check_w("flush_next_rt", 128'(seen_rt), 128'(7'h55));
        check_w("flush_next_res", seen_res, ref_shift(eo, ea, eb, ei));

        // reset mid-stream, then a reserved op, then normal resume
        pulses = 0;
        drive(1'b1, 3'd3, rnd128(), '0, 7'h7F, 7'h21, 1'b0);
        drive(1'b1, 3'd0, rnd128(), rnd128(), 7'h00, 7'h22, 1'b0);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        rst_n = 1'b0;
        #2;
        check_b("rst_mid_valid", valid_out, 1'b0);
        check_w("rst_mid_result", result, '0);
        check_w("rst_mid_rt", 128'(rt_out), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 3'd6, rnd128(), rnd128(), 7'h01, 7'h23, 1'b0);
        idle(10);
        check_w("rst_reserved_pulses", 128'(pulses), '0);
        check_w("rst_after_result", result, '0);
        pulses = 0;
        drive(1'b1, 3'd3, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, '0, 7'h7D, 7'h24, 1'b0);
        idle(8);
        check_w("resume_pulses", 128'(pulses), 128'(1));
        check_w("resume_result", seen_res, 128'h0000_0000_1122_3344_5566_7788_99AA_BBCC);

        // randomized traffic against the reference model
        for (int k = 0; k < 400; k++)
            drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), rnd128(), rnd128(),
                  7'($urandom()), 7'($urandom()), 1'($urandom_range(0, 15) == 0));
        idle(12);
        check_b("sb_drained", exp_q.size() == 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
